// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-expansion engine: mode encodings,
// per-mode schedule sizes, GF(2^8) helpers and the FSM state type.
package aes_key_pkg;

  localparam logic [1:0] MODE_AES128 = 2'h1;
  localparam logic [1:0] MODE_AES192 = 2'h2;
  localparam logic [1:0] MODE_AES256 = 2'h3;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef enum logic {IDLE, EXPAND} state_t;

  // Mode 0 is treated as AES-128.
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_AES192: return 4'd6;
      MODE_AES256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    return nk_of(m) + 4'd6;
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] m);
    return {nr_of(m) + 4'd1, 2'b00};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the
  // affine transform; avoids carrying a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_subword.sv
// SubWord: four parallel S-box lanes, 32 bits in, 32 bits out.
// RotWord is applied by the caller.
module key_subword
  import aes_key_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key expansion: one schedule word per cycle into a local
// store, 128-bit round keys served over a registered read port.
// Optional feature macro: AES_KEY_ZEROIZE_EN (adds a zeroize input that
// wipes the store, rcon and read data and forces IDLE).
//
// state  | meaning
// IDLE   | waiting for start; schedule (if keys_valid) readable
// EXPAND | writing w[i], i = Nk .. Nw-1, one word per cycle
module aes_key_expand
  import aes_key_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic [127:0] rd_data
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  state_t      state;
  logic [1:0]  mode_q;
  logic [5:0]  i_q;
  logic [3:0]  kmod_q;
  logic [7:0]  rcon_q;
  logic [31:0] store [DEPTH];

  logic        zero;
  logic [3:0]  nk_req, nk_cur;
  logic        start_ok, last_word;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif

  assign nk_req    = nk_of(mode);
  assign nk_cur    = nk_of(mode_q);
  assign start_ok  = (state == IDLE) && start && (nk_req <= MAX_NK_L) && !zero;
  assign last_word = (i_q == nw_of(mode_q) - 6'd1);

  assign w_prev = store[i_q - 6'd1];
  assign w_back = store[i_q - {2'b00, nk_cur}];
  assign sub_in = (kmod_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  key_subword u_subword (.din(sub_in), .dout(sub_out));

  // Next schedule word from w[i-1] and w[i-Nk]
  always_comb begin
    if (kmod_q == 4'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_cur == 4'd8 && i_q[1:0] == 2'b00)
      temp = sub_out;
    else
      temp = w_prev;
    w_new = w_back ^ temp;
  end

  // Key store: cipher key load on accepted start, then one word per cycle
  always_ff @(posedge clk) begin
    if (zero) begin
      for (int j = 0; j < DEPTH; j++) store[j] <= 32'h0;
    end else if (start_ok) begin
      for (int j = 0; j < 8; j++)
        if (4'(j) < nk_req) store[j] <= key[255 - 32*j -: 32];
    end else if (state == EXPAND) begin
      store[i_q] <= w_new;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= MODE_AES128;
      i_q        <= 6'd0;
      kmod_q     <= 4'd0;
      rcon_q     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (zero) begin
        state      <= IDLE;
        i_q        <= 6'd0;
        kmod_q     <= 4'd0;
        rcon_q     <= 8'h00;
        busy       <= 1'b0;
        keys_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (nk_req > MAX_NK_L) begin
                err <= 1'b1;
              end else begin
                mode_q     <= mode;
                i_q        <= {2'b00, nk_req};
                kmod_q     <= 4'd0;
                rcon_q     <= RCON_INIT;
                busy       <= 1'b1;
                keys_valid <= 1'b0;
                state      <= EXPAND;
              end
            end
          end
          EXPAND: begin
            if (kmod_q == 4'd0) rcon_q <= xtime(rcon_q);
            kmod_q <= (kmod_q == nk_cur - 4'd1) ? 4'd0 : kmod_q + 4'd1;
            i_q    <= i_q + 6'd1;
            if (last_word) begin
              done       <= 1'b1;
              keys_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        endcase
      end
    end
  end

  logic         rd_hit;
  logic [5:0]   rd_base;
  logic [127:0] rd_word;
  logic         rv1;
  logic [127:0] rd1;

  assign rd_hit  = rd_en && keys_valid && (rd_idx <= nr_of(mode_q));
  assign rd_base = {rd_idx, 2'b00};
  assign rd_word = {store[rd_base], store[rd_base + 6'd1],
                    store[rd_base + 6'd2], store[rd_base + 6'd3]};

  // First read stage: qualify the request and capture the round key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1 <= 1'b0;
      rd1 <= '0;
    end else if (zero) begin
      rv1 <= 1'b0;
      rd1 <= '0;
    end else begin
      rv1 <= rd_hit;
      rd1 <= rd_hit ? rd_word : '0;
    end
  end

  if (RD_LAT == 2) begin : g_rd_lat2
    // Extra output register for the two-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (zero) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rv1;
        rd_data  <= rd1;
      end
    end
  end else begin : g_rd_lat1
    assign rd_valid = rv1;
    assign rd_data  = rd1;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: known-answer vectors, randomized
// keys against a table-driven FIPS-197 reference, read-port boundaries,
// oversize-Nk error and mid-expansion reset.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'h1;
  logic [255:0] key = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_idx = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  logic         busy, done, keys_valid, err, rd_valid;
  logic [127:0] rd_data;
  logic         busy4, done4, keys_valid4, err4, rd_valid4;
  logic [127:0] rd_data4;

  int n_cmp = 0;
  int n_bad = 0;

  int          exp_t [256];
  int          log_t [256];
  logic [31:0] ref_w [60];

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy), .done(done), .keys_valid(keys_valid), .err(err),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  aes_key_expand #(.MAX_NK(4), .RD_LAT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy4), .done(done4), .keys_valid(keys_valid4), .err(err4),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid4), .rd_data(rd_data4)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // exp/log tables over generator 3
  task automatic init_tables();
    logic [7:0] e;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = int'(e);
      log_t[e] = i;
      e = e ^ mul2(e);
    end
  endtask

  function automatic logic [7:0] sb_ref(input logic [7:0] x);
    logic [7:0] v, s;
    v = (x == 8'h00) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
    s = 8'h63;
    for (int k = 0; k < 5; k++) s = s ^ ((v << k) | (v >> (8 - k)));
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_ref(t[31:24]), sb_ref(t[23:16]), sb_ref(t[15:8]), sb_ref(t[7:0])};
  endfunction

  function automatic int nk_for(input logic [1:0] m);
    return (m == 2'h3) ? 8 : (m == 2'h2) ? 6 : 4;
  endfunction

  function automatic void ref_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = mul2(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Starts an expansion and returns edges from start to done (-1 on timeout).
  // If poke > 0, a conflicting start is pulsed before that edge.
  task automatic run_expand(input logic [1:0] m, input logic [255:0] k, input int poke,
                            output int lat, output bit saw_err);
    @(posedge clk); #1;
    mode = m; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = -1; saw_err = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == poke) begin start = 1'b1; mode = 2'h3; key = ~k; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (err) saw_err = 1'b1;
      if (done) begin lat = c; break; end
    end
    start = 1'b0; mode = m; key = k;
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic v, output logic [127:0] d);
    rd_en = 1'b1; rd_idx = idx;
    @(posedge clk); #1;
    v = rd_valid; d = rd_data;
    rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL reset_keys_valid got %b want 0", keys_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 128'h0) begin
      n_bad++; $display("FAIL reset_rd got %b/%h want 0/0", rd_valid, rd_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_kat();
    logic [255:0] k [3];
    logic [127:0] exp_last [3];
    int           exp_lat [3];
    int           lat;
    bit           se;
    logic         v;
    logic [127:0] d;
    logic [1:0]   m;
    k[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    exp_last[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_last[1] = 128'he98ba06f448c773c8ecc720401002202;
    exp_last[2] = 128'hfe4890d1e6188d0b046df344706c631e;
    exp_lat[0] = 40; exp_lat[1] = 46; exp_lat[2] = 52;
    for (int t = 0; t < 3; t++) begin
      m = 2'(t + 1);
      run_expand(m, k[t], 0, lat, se);
      n_cmp++; if (lat != exp_lat[t]) begin
        n_bad++; $display("FAIL kat_latency mode=%0d got %0d want %0d", m, lat, exp_lat[t]); end
      n_cmp++; if (se !== 1'b0 || keys_valid !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL kat_flags mode=%0d err=%b kv=%b busy=%b want 0/1/0", m, se, keys_valid, busy); end
      read_rk(4'(10 + 2*t), v, d);
      n_cmp++; if (v !== 1'b1 || d !== exp_last[t]) begin
        n_bad++; $display("FAIL kat_last mode=%0d got %b/%h want 1/%h", m, v, d, exp_last[t]); end
      @(posedge clk); #1;
      n_cmp++; if (rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL kat_rd_drop got %b want 0", rd_valid); end
      if (t == 0) begin
        read_rk(4'd0, v, d);
        n_cmp++; if (v !== 1'b1 || d !== k[0][255:128]) begin
          n_bad++; $display("FAIL kat_rk0 got %b/%h want 1/%h", v, d, k[0][255:128]); end
      end
    end
  endtask

  task automatic test_err();
    int   c;
    logic [127:0] exp10;
    exp10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    // dut4 still holds the AES-128 schedule; read with two-cycle latency
    rd_en = 1'b1; rd_idx = 4'd10;
    @(posedge clk); #1;
    rd_en = 1'b0;
    n_cmp++; if (rd_valid4 !== 1'b0) begin
      n_bad++; $display("FAIL lat2_early got %b want 0", rd_valid4); end
    @(posedge clk); #1;
    n_cmp++; if (rd_valid4 !== 1'b1 || rd_data4 !== exp10) begin
      n_bad++; $display("FAIL lat2_data got %b/%h want 1/%h", rd_valid4, rd_data4, exp10); end
    mode = 2'h3; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (err4 !== 1'b1) begin n_bad++; $display("FAIL err_pulse got %b want 1", err4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL err_busy got %b want 0", busy4); end
    n_cmp++; if (keys_valid4 !== 1'b1) begin n_bad++; $display("FAIL err_kv got %b want 1", keys_valid4); end
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL err_main err=%b busy=%b want 0/1", err, busy); end
    @(posedge clk); #1;
    n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL err_width got %b want 0", err4); end
    c = 0;
    while (!done && c < 200) begin @(posedge clk); #1; c++; end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL err_main_done got timeout want done"); end
    n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL err_done4 got %b want 0", done4); end
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic [1:0]   m;
    int           nk, nr, lat;
    bit           se;
    logic         v;
    logic [127:0] d, e;
    for (int it = 0; it < 6; it++) begin
      m  = 2'($urandom_range(0, 3));
      k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nk = nk_for(m); nr = nk + 6;
      ref_expand(k, nk);
      run_expand(m, k, 0, lat, se);
      n_cmp++; if (lat != 4 * (nr + 1) - nk) begin
        n_bad++; $display("FAIL rand_latency mode=%0d got %0d want %0d", m, lat, 4*(nr+1)-nk); end
      for (int r = 0; r <= nr; r++) begin
        e = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
        read_rk(4'(r), v, d);
        n_cmp++; if (v !== 1'b1 || d !== e) begin
          n_bad++; $display("FAIL rand_rk mode=%0d idx=%0d got %b/%h want 1/%h", m, r, v, d, e); end
      end
      if (nr < 15) begin
        read_rk(4'(nr + 1), v, d);
        n_cmp++; if (v !== 1'b0 || d !== 128'h0) begin
          n_bad++; $display("FAIL rand_oob mode=%0d got %b/%h want 0/0", m, v, d); end
      end
    end
  endtask

  task automatic test_bounds();
    logic [255:0] k;
    int           lat, c;
    bit           se;
    logic         v;
    logic [127:0] d, e;
    // out-of-range index after AES-128
    k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    run_expand(2'h1, k, 0, lat, se);
    read_rk(4'd11, v, d);
    n_cmp++; if (v !== 1'b0 || d !== 128'h0) begin
      n_bad++; $display("FAIL oob11 got %b/%h want 0/0", v, d); end
    // read while busy
    @(posedge clk); #1;
    mode = 2'h2; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    read_rk(4'd0, v, d);
    n_cmp++; if (v !== 1'b0 || d !== 128'h0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL read_busy got %b/%h busy=%b want 0/0 busy=1", v, d, busy); end
    c = 0;
    while (!done && c < 200) begin @(posedge clk); #1; c++; end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL read_busy_done got timeout want done"); end
    // conflicting start mid-expansion is ignored
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
    ref_expand(k, 6);
    run_expand(2'h2, k, 10, lat, se);
    n_cmp++; if (lat != 46 || se !== 1'b0) begin
      n_bad++; $display("FAIL mid_start lat=%0d err=%b want 46/0", lat, se); end
    e = {ref_w[48], ref_w[49], ref_w[50], ref_w[51]};
    read_rk(4'd12, v, d);
    n_cmp++; if (v !== 1'b1 || d !== e) begin
      n_bad++; $display("FAIL mid_start_rk got %b/%h want 1/%h", v, d, e); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    int           lat;
    bit           se;
    logic         v;
    logic [127:0] d;
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    @(posedge clk); #1;
    mode = 2'h1; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({busy, done, keys_valid, err, rd_valid} !== 5'b0 || rd_data !== 128'h0) begin
      n_bad++; $display("FAIL rst_mid got b%b d%b kv%b e%b rv%b rd=%h want all 0",
                        busy, done, keys_valid, err, rd_valid, rd_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_idle busy=%b kv=%b want 0/0", busy, keys_valid); end
    run_expand(2'h1, k, 0, lat, se);
    n_cmp++; if (lat != 40) begin n_bad++; $display("FAIL rst_mid_lat got %0d want 40", lat); end
    read_rk(4'd10, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_bad++; $display("FAIL rst_mid_rk got %b/%h want 1/d014f9a8c9ee2589e13f0cc8b6630ca6", v, d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    init_tables();
    test_reset();
    test_kat();
    test_err();
    test_random();
    test_bounds();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
